// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with signed/unsigned mode, start/busy/done handshake and abort.
// Result is registered and held until the next completed operation.
module booth_mult_seq #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic               op_signed_i,
   input  logic               abort_i,
   input  logic [WIDTH-1:0]   mc_i,
   input  logic [WIDTH-1:0]   mp_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [2*WIDTH-1:0] prod_o
);
   localparam int            W1   = WIDTH + 1;
   localparam int            CW   = $clog2(W1) + 1;
   localparam logic [CW-1:0] LAST = CW'(W1);

   // state | meaning
   // IDLE  | waiting for start
   // RUN   | one Booth step per clock, W1 steps total
   // DONE  | one-cycle done pulse; start accepted back-to-back
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q;
   logic [W1-1:0]      a_q, q_q, m_q;
   logic               q1_q;
   logic [CW-1:0]      count_q, count_d;
   logic               busy_q, done_q;
   logic [2*WIDTH-1:0] prod_q;

   logic [W1-1:0]      mc_ext, mp_ext, sum_d, a_d, q_d;

   // The extra operand bit lets unsigned values run through the signed Booth datapath.
   always_comb begin
      mc_ext = {op_signed_i & mc_i[WIDTH-1], mc_i};
      mp_ext = {op_signed_i & mp_i[WIDTH-1], mp_i};
      case ({q_q[0], q1_q})
         2'b01:   sum_d = a_q + m_q;
         2'b10:   sum_d = a_q + ~m_q + W1'(1);
         default: sum_d = a_q;
      endcase
      a_d     = {sum_d[W1-1], sum_d[W1-1:1]};
      q_d     = {sum_d[0], q_q[W1-1:1]};
      count_d = count_q + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         q_q     <= '0;
         m_q     <= '0;
         q1_q    <= 1'b0;
         count_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         prod_q  <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  a_q     <= '0;
                  m_q     <= mc_ext;
                  q_q     <= mp_ext;
                  q1_q    <= 1'b0;
                  count_q <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               if (abort_i) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  a_q     <= a_d;
                  q_q     <= q_d;
                  q1_q    <= q_q[0];
                  count_q <= count_d;
                  if (count_d == LAST) begin
                     prod_q  <= {a_d[WIDTH-2:0], q_d};
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign prod_o = prod_q;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: WIDTH=8 and WIDTH=32 instances against a cycle-count/arithmetic model,
// with directed literal checks and randomized operations.
`timescale 1ns/1ps
module tb_booth_mult_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        st[2], sg[2], ab[2];
   logic [31:0] mcv[2], mpv[2];
   logic        b8, d8, b32, d32;
   logic [15:0] p8;
   logic [63:0] p32;

   int vectors = 0;
   int miscompares = 0;

   booth_mult_seq #(.WIDTH(8)) u8 (
      .clk(clk), .rst_n(rst_n), .start_i(st[0]), .op_signed_i(sg[0]), .abort_i(ab[0]),
      .mc_i(mcv[0][7:0]), .mp_i(mpv[0][7:0]), .busy_o(b8), .done_o(d8), .prod_o(p8));

   booth_mult_seq #(.WIDTH(32)) u32 (
      .clk(clk), .rst_n(rst_n), .start_i(st[1]), .op_signed_i(sg[1]), .abort_i(ab[1]),
      .mc_i(mcv[1]), .mp_i(mpv[1]), .busy_o(b32), .done_o(d32), .prod_o(p32));

   function automatic int wid(input int i);
      return (i == 0) ? 8 : 32;
   endfunction

   // Exact product of the extended operands, truncated to 2*w bits.
   function automatic logic [63:0] ref_prod(input int w, input bit sgn, input logic [31:0] a,
                                            input logic [31:0] b);
      longint      xa, xb;
      logic [63:0] mask, r;
      mask = (w == 32) ? 64'h0000_0000_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      xa = longint'(a & mask[31:0]);
      xb = longint'(b & mask[31:0]);
      if (sgn && a[w-1]) xa = xa - longint'(64'd1 << w);
      if (sgn && b[w-1]) xb = xb - longint'(64'd1 << w);
      r = xa * xb;
      if (w < 32) r = r & ((64'd1 << (2*w)) - 64'd1);
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: busy for W1 cycles after an accepted start, then a done pulse with the exact product.
   bit          mb[2], md[2];
   int          ml[2];
   logic [63:0] mprod[2], mpend[2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            mb[i] = 0; md[i] = 0; ml[i] = 0; mprod[i] = '0; mpend[i] = '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            md[i] = 0;
            if (mb[i]) begin
               if (ab[i]) mb[i] = 0;
               else begin
                  ml[i] = ml[i] - 1;
                  if (ml[i] == 0) begin
                     mb[i] = 0; md[i] = 1; mprod[i] = mpend[i];
                  end
               end
            end else if (st[i]) begin
               mb[i] = 1;
               ml[i] = wid(i) + 1;
               mpend[i] = ref_prod(wid(i), sg[i], mcv[i], mpv[i]);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("busy8", {63'd0, b8}, {63'd0, mb[0]});
         chk("done8", {63'd0, d8}, {63'd0, md[0]});
         chk("prod8", {48'd0, p8}, mprod[0]);
         chk("busy32", {63'd0, b32}, {63'd0, mb[1]});
         chk("done32", {63'd0, d32}, {63'd0, md[1]});
         chk("prod32", p32, mprod[1]);
      end
   end

   task automatic launch(input int i, input bit sgn, input logic [31:0] a, input logic [31:0] b);
      st[i] = 1'b1; sg[i] = sgn; mcv[i] = a; mpv[i] = b;
      @(negedge clk);
      st[i] = 1'b0;
   endtask

   task automatic wait_done(input int i, output int nbusy);
      int n;
      n = 0;
      nbusy = 0;
      while (!((i == 0) ? d8 : d32)) begin
         if ((i == 0) ? b8 : b32) nbusy++;
         @(negedge clk);
         n++;
         if (n > 200) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: unit %0d no done after %0d cycles", i, n);
            return;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          nb, i, gap;
      bit          sgn, seen;
      logic [31:0] a, b;
      time         t1, t2;

      for (int k = 0; k < 2; k++) begin
         st[k] = 0; sg[k] = 0; ab[k] = 0; mcv[k] = '0; mpv[k] = '0;
      end
      repeat (2) @(negedge clk);
      chk("rst_busy8", {63'd0, b8}, 64'd0);
      chk("rst_done8", {63'd0, d8}, 64'd0);
      chk("rst_prod8", {48'd0, p8}, 64'd0);
      chk("rst_prod32", p32, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      chk("model_pin_neg35", ref_prod(8, 1'b1, 32'hF9, 32'h5), 64'hFFDD);
      launch(0, 1'b1, 32'hF9, 32'h05);
      wait_done(0, nb);
      chk("t1_busy_cycles", 64'(nb), 64'd9);
      chk("t1_prod", {48'd0, p8}, 64'hFFDD);

      launch(0, 1'b0, 32'hFF, 32'hFF);
      wait_done(0, nb);
      chk("t2_unsigned", {48'd0, p8}, 64'hFE01);
      launch(0, 1'b1, 32'hFF, 32'hFF);
      wait_done(0, nb);
      chk("t2_signed", {48'd0, p8}, 64'h0001);

      launch(1, 1'b1, 32'h8000_0000, 32'h8000_0000);
      wait_done(1, nb);
      chk("t3_busy_cycles", 64'(nb), 64'd33);
      chk("t3_prod", p32, 64'h4000_0000_0000_0000);
      launch(1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(1, nb);
      chk("t3_unsigned_max", p32, 64'hFFFF_FFFE_0000_0001);

      @(negedge clk);
      st[0] = 1'b1; sg[0] = 1'b0; mcv[0] = 32'd3; mpv[0] = 32'd5;
      @(negedge clk);
      mcv[0] = 32'd4; mpv[0] = 32'd6;
      wait_done(0, nb);
      chk("t4_first", {48'd0, p8}, 64'd15);
      t1 = $time;
      @(negedge clk);
      st[0] = 1'b0;
      chk("t4_held_prod", {48'd0, p8}, 64'd15);
      wait_done(0, nb);
      chk("t4_second", {48'd0, p8}, 64'd24);
      t2 = $time;
      chk("t4_interval", 64'((t2 - t1) / 10), 64'd10);

      @(negedge clk);
      launch(0, 1'b0, 32'd3, 32'd5);
      wait_done(0, nb);
      launch(0, 1'b0, 32'd2, 32'd3);
      st[0] = 1'b1; mcv[0] = 32'd99; mpv[0] = 32'd77;
      @(negedge clk);
      st[0] = 1'b0;
      @(negedge clk);
      ab[0] = 1'b1;
      @(negedge clk);
      ab[0] = 1'b0;
      chk("t5_busy_dropped", {63'd0, b8}, 64'd0);
      chk("t5_prod_kept", {48'd0, p8}, 64'd15);
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         seen = seen | d8;
      end
      chk("t5_no_done", {63'd0, seen}, 64'd0);

      launch(0, 1'b1, 32'h5A, 32'hC3);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_busy", {63'd0, b8}, 64'd0);
      chk("t6_done", {63'd0, d8}, 64'd0);
      chk("t6_prod", {48'd0, p8}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      launch(0, 1'b0, 32'd7, 32'd9);
      wait_done(0, nb);
      chk("t6_after_busy", 64'(nb), 64'd9);
      chk("t6_after_prod", {48'd0, p8}, 64'd63);

      for (int n = 0; n < 40; n++) begin
         i   = (n % 5 == 4) ? 1 : 0;
         sgn = 1'($urandom_range(0, 1));
         a   = $urandom;
         b   = $urandom;
         gap = $urandom_range(0, 3);
         repeat (gap) @(negedge clk);
         launch(i, sgn, a, b);
         if ($urandom_range(0, 5) == 0) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            ab[i] = 1'b1;
            @(negedge clk);
            ab[i] = 1'b0;
         end else begin
            wait_done(i, nb);
            chk("rand_latency", 64'(nb), 64'(wid(i) + 1));
            ab[i] = 1'($urandom_range(0, 1));
            @(negedge clk);
            ab[i] = 1'b0;
         end
      end
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
